pipe_stage_skid: RTL



---
 rtl/pipe_stage_skid_if.sv | 27 ++
 rtl/pipe_stage_skid.sv | 113 +++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid; stage side uses the slave modport, the driving side uses master.
// Names follow the stage's view: *_i enter the stage, *_o leave it.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8
);
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] data_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic              hold_i;
  logic              flush_i;

  modport master (
    output valid_i, data_i, ctrl_i, ready_i, hold_i, flush_i,
    input  ready_o, valid_o, data_o, ctrl_o
  );

  modport slave (
    input  valid_i, data_i, ctrl_i, ready_i, hold_i, flush_i,
    output ready_o, valid_o, data_o, ctrl_o
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with 2-entry skid, hold and flush-to-bubble; 1-cycle latency, 1 bundle/cycle.
// Backpressure: ready_o is registered (~skid full); optional stall counter under STAGE_STALL_CNT_EN.
module pipe_stage_skid #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipe_stage_skid_if.slave bus
`ifdef STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  logic              main_v_q,    main_v_d;
  logic              skid_v_q,    skid_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  logic eff_rdy;
  logic acc;
  logic out_fire;

  assign eff_rdy  = bus.ready_i & ~bus.hold_i;
  assign acc      = bus.valid_i & ~skid_v_q;
  assign out_fire = main_v_q & eff_rdy;

  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    // Flush only clears the valid bits; payload registers are left as they were.
    if (bus.flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || out_fire) begin
      if (skid_v_q) begin
        main_v_d    = 1'b1;
        main_data_d = skid_data_q;
        main_ctrl_d = skid_ctrl_q;
        skid_v_d    = acc;
        if (acc) begin
          skid_data_d = bus.data_i;
          skid_ctrl_d = bus.ctrl_i;
        end
      end else begin
        main_v_d = acc;
        if (acc) begin
          main_data_d = bus.data_i;
          main_ctrl_d = bus.ctrl_i;
        end
      end
    end else if (acc) begin
      skid_v_d    = 1'b1;
      skid_data_d = bus.data_i;
      skid_ctrl_d = bus.ctrl_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign bus.valid_o = main_v_q;
  assign bus.data_o  = main_data_q;
  assign bus.ctrl_o  = main_v_q ? main_ctrl_q : '0;
  assign bus.ready_o = ~skid_v_q;

`ifdef STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where a valid bundle is blocked; flush does not clear it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_v_q && !eff_rdy && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
